// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b over WIDTH clocks, LSB first,
// with a start/busy/done handshake and held result/borrow/overflow flags.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic               brw;
  logic [CNT_W-1:0]   cnt;
  logic               a_sign, b_sign;

  logic               d_c;
  logic               brw_n_c;
  logic               last_c;
  logic [WIDTH-1:0]   res_n_c;

  // Full-subtractor cell on the current LSBs
  assign d_c     = a_sr[0] ^ b_sr[0] ^ brw;
  assign brw_n_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
  assign res_n_c = {d_c, res_sr[WIDTH-1:1]};
  assign last_c  = (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last_c) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      a_sign     <= 1'b0;
      b_sign     <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= (state_n == SHIFT);
      done <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          res_sr <= res_n_c;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          brw    <= brw_n_c;
          if (last_c) begin
            // Counter clears on the final bit so it can never drive an extra shift
            cnt        <= '0;
            diff       <= res_n_c;
            borrow_out <= brw_n_c;
            ovf        <= (a_sign != b_sign) && (res_n_c[WIDTH-1] != a_sign);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
